voice_frame_scheduler: RTL and testbench

VOICE_FRAME_SCHEDULER -- requirements
Module: voice_frame_scheduler

---
 rtl/voice_frame_scheduler.sv | 166 ++++++++++++++++
 tb/tb_voice_frame_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_frame_scheduler.sv
// Voice frame scheduler: on each codec frame, polls the enabled voices in index
// order, sums their samples into an 18-bit accumulator and emits a saturated mix.
module voice_frame_scheduler #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk_100,
  input  logic                       reset,
  input  logic                       new_frame,
  input  logic [NUM_VOICES-1:0]      voice_enable,
  output logic [NUM_VOICES-1:0]      gen_req,
  input  logic [NUM_VOICES-1:0]      voice_valid,
  input  logic [16*NUM_VOICES-1:0]   voice_sample,
  output logic [15:0]                sample_out,
  output logic                       new_sample_generated,
  output logic [1:0]                 status
);

  localparam int unsigned IW = $clog2(NUM_VOICES + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = 18;

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, DONE} state_t;

  state_t                  state, state_d;
  logic [NUM_VOICES-1:0]   en_q, en_d;
  logic signed [AW-1:0]    acc, acc_d;
  logic [IW-1:0]           idx, idx_d;
  logic [CW-1:0]           wait_cnt, wait_d;
  logic [NUM_VOICES-1:0]   gen_req_d;
  logic [15:0]             sample_out_d;
  logic                    nsg_d;
  logic [1:0]              status_d;

  logic                    found;
  logic [IW-1:0]           sel;
  logic                    cur_valid;
  logic [15:0]             cur_sample;
  logic signed [AW-1:0]    cur_ext;
  logic [15:0]             clamped;
  logic                    expired;

  // Lowest enabled voice at or above the current index; one-cycle scan.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (en_q[i] && (IW'(i) >= idx)) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  // Only the voice currently being waited on is observed.
  always_comb begin
    cur_valid  = 1'b0;
    cur_sample = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (IW'(i) == idx) begin
        cur_valid  = voice_valid[i];
        cur_sample = voice_sample[16*i +: 16];
      end
    end
  end

  assign cur_ext = $signed({{(AW-16){cur_sample[15]}}, cur_sample});
  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    if (acc > 18'sd32767)
      clamped = 16'h7FFF;
    else if (acc < -18'sd32768)
      clamped = 16'h8000;
    else
      clamped = acc[15:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      en_q                 <= '0;
      acc                  <= '0;
      idx                  <= '0;
      wait_cnt             <= '0;
      gen_req              <= '0;
      sample_out           <= '0;
      new_sample_generated <= 1'b0;
      status               <= '0;
    end else begin
      state                <= state_d;
      en_q                 <= en_d;
      acc                  <= acc_d;
      idx                  <= idx_d;
      wait_cnt             <= wait_d;
      gen_req              <= gen_req_d;
      sample_out           <= sample_out_d;
      new_sample_generated <= nsg_d;
      status               <= status_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (new_frame) state_d = SELECT;
      SELECT:  state_d = found ? ISSUE : DONE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cur_valid || expired) state_d = SELECT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    en_d         = en_q;
    acc_d        = acc;
    idx_d        = idx;
    wait_d       = wait_cnt;
    gen_req_d    = '0;
    sample_out_d = sample_out;
    nsg_d        = 1'b0;
    status_d     = status;

    case (state)
      IDLE: begin
        if (new_frame) begin
          en_d  = voice_enable;
          acc_d = '0;
          idx_d = '0;
        end
      end
      SELECT: begin
        if (found) begin
          idx_d     = sel;
          gen_req_d = NUM_VOICES'(1) << sel;
        end
      end
      ISSUE: wait_d = '0;
      WAIT: begin
        if (cur_valid) begin
          acc_d = acc + cur_ext;
          idx_d = idx + IW'(1);
        end else if (expired) begin
          status_d[1] = 1'b1;
          idx_d       = idx + IW'(1);
        end else begin
          wait_d = wait_cnt + CW'(1);
        end
      end
      DONE: begin
        sample_out_d = clamped;
        nsg_d        = 1'b1;
      end
      default: ;
    endcase

    // A frame request outside IDLE (including the DONE cycle) is dropped.
    if (new_frame && (state != IDLE))
      status_d[0] = 1'b1;
  end

endmodule

// File: tb/tb_voice_frame_scheduler.sv
// Directed bench for voice_frame_scheduler with a simple voice responder model.
module tb_voice_frame_scheduler;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        new_frame;
  logic [2:0]  voice_enable;
  logic [2:0]  gen_req;
  logic [2:0]  voice_valid;
  logic [47:0] voice_sample;
  logic [15:0] sample_out;
  logic        new_sample_generated;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  logic [2:0]  resp_en;
  logic [15:0] resp_val [3];
  logic [2:0]  pending;
  logic [2:0]  gen_log [$];

  voice_frame_scheduler #(.NUM_VOICES(3), .TIMEOUT(64)) dut (
    .clk_100(clk_100),
    .reset(reset),
    .new_frame(new_frame),
    .voice_enable(voice_enable),
    .gen_req(gen_req),
    .voice_valid(voice_valid),
    .voice_sample(voice_sample),
    .sample_out(sample_out),
    .new_sample_generated(new_sample_generated),
    .status(status)
  );

  always #5 clk_100 = ~clk_100;

  // Voices answer during the cycle after their gen_req pulse.
  always @(negedge clk_100) begin
    voice_valid = pending;
    for (int i = 0; i < 3; i++)
      if (pending[i]) voice_sample[16*i +: 16] = resp_val[i];
    pending = gen_req & resp_en;
    if (gen_req != 3'b000) gen_log.push_back(gen_req);
  end

  // Runs one frame from a negedge; an extra new_frame is raised in cycle extra_at.
  task automatic frame(input logic [2:0] en, input int extra_at,
                       output int lat, output int npulse);
    gen_log.delete();
    new_frame    = 1'b1;
    voice_enable = en;
    lat          = -1;
    npulse       = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_100);
      if (new_sample_generated) begin
        npulse++;
        if (lat < 0) lat = k;
      end
      new_frame    = (k == extra_at);
      voice_enable = ~en;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; new_frame = 1'b0; voice_enable = '0;
    voice_valid = '0; voice_sample = '0; pending = '0; resp_en = '0;
    resp_val[0] = '0; resp_val[1] = '0; resp_val[2] = '0;
    repeat (3) @(negedge clk_100);
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h expected 0000", sample_out); end
    checks++; if (gen_req !== 3'b000) begin errors++; $display("FAIL reset_gen_req: got %b expected 000", gen_req); end
    checks++; if (new_sample_generated !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", new_sample_generated); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", status); end
    reset = 1'b0;
    repeat (2) @(negedge clk_100);
  endtask

  task automatic test_basic();
    int lat, np;
    resp_en = 3'b111;
    resp_val[0] = 16'd100; resp_val[1] = -16'sd50; resp_val[2] = 16'd25;
    frame(3'b111, 0, lat, np);
    checks++; if (lat != 12) begin errors++; $display("FAIL basic_latency: got %0d expected 12", lat); end
    checks++; if (np != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", np); end
    checks++; if ($signed(sample_out) != 75) begin errors++; $display("FAIL basic_sum: got %0d expected 75", $signed(sample_out)); end
    checks++;
    if (gen_log.size() != 3 || gen_log[0] !== 3'b001 || gen_log[1] !== 3'b010 || gen_log[2] !== 3'b100) begin
      errors++; $display("FAIL basic_gen_order: got %0d pulses expected 001,010,100", gen_log.size());
    end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL basic_status: got %b expected 00", status); end
  endtask

  task automatic test_saturation();
    int lat, np;
    resp_en = 3'b111;
    resp_val[0] = 16'd30000; resp_val[1] = 16'd30000; resp_val[2] = -16'sd1000;
    frame(3'b111, 0, lat, np);
    checks++; if (sample_out !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", $signed(sample_out)); end
    resp_val[0] = -16'sd30000; resp_val[1] = -16'sd30000; resp_val[2] = -16'sd30000;
    frame(3'b111, 0, lat, np);
    checks++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", $signed(sample_out)); end
  endtask

  task automatic test_sparse();
    int lat, np;
    resp_en = 3'b111;
    resp_val[0] = 16'd7; resp_val[1] = 16'd500; resp_val[2] = 16'd9;
    frame(3'b101, 0, lat, np);
    checks++; if ($signed(sample_out) != 16) begin errors++; $display("FAIL sparse_sum: got %0d expected 16", $signed(sample_out)); end
    checks++;
    if (gen_log.size() != 2 || gen_log[0] !== 3'b001 || gen_log[1] !== 3'b100) begin
      errors++; $display("FAIL sparse_gen: got %0d pulses expected 001,100", gen_log.size());
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL sparse_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_empty();
    int lat, np;
    frame(3'b000, 0, lat, np);
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL empty_sum: got %0d expected 0", $signed(sample_out)); end
    checks++; if (lat != 3) begin errors++; $display("FAIL empty_latency: got %0d expected 3", lat); end
    checks++; if (gen_log.size() != 0) begin errors++; $display("FAIL empty_gen: got %0d pulses expected 0", gen_log.size()); end
  endtask

  task automatic test_timeout();
    int lat, np;
    resp_en = 3'b001;
    resp_val[0] = 16'd5; resp_val[1] = 16'd1234;
    frame(3'b011, 0, lat, np);
    checks++; if ($signed(sample_out) != 5) begin errors++; $display("FAIL timeout_sum: got %0d expected 5", $signed(sample_out)); end
    checks++; if (lat != 72) begin errors++; $display("FAIL timeout_latency: got %0d expected 72", lat); end
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL timeout_status: got %b expected 10", status); end
  endtask

  task automatic test_overrun();
    int lat, np;
    resp_en = 3'b111;
    resp_val[0] = 16'd1; resp_val[1] = 16'd2; resp_val[2] = 16'd3;
    frame(3'b111, 2, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", np); end
    checks++; if ($signed(sample_out) != 6) begin errors++; $display("FAIL overrun_sum: got %0d expected 6", $signed(sample_out)); end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL overrun_status: got %b expected 11", status); end
    resp_val[0] = 16'd4;
    frame(3'b001, 0, lat, np);
    checks++; if ($signed(sample_out) != 4 || lat != 6) begin errors++; $display("FAIL overrun_next: got %0d lat %0d expected 4 lat 6", $signed(sample_out), lat); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, np;
    resp_en = 3'b000;
    new_frame = 1'b1; voice_enable = 3'b111;
    @(negedge clk_100);
    new_frame = 1'b0;
    repeat (5) @(negedge clk_100);
    @(posedge clk_100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sample_out !== 16'h0000 || status !== 2'b00 || gen_req !== 3'b000 || new_sample_generated !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: got out %h st %b req %b p %b expected all 0", sample_out, status, gen_req, new_sample_generated);
    end
    @(negedge clk_100);
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_100);
      if (new_sample_generated) np++;
    end
    checks++; if (np != 0) begin errors++; $display("FAIL midwait_no_pulse: got %0d expected 0", np); end
    resp_en = 3'b111;
    resp_val[0] = 16'd10; resp_val[1] = 16'd20; resp_val[2] = 16'd30;
    frame(3'b111, 0, lat, np);
    checks++; if ($signed(sample_out) != 60 || lat != 12) begin errors++; $display("FAIL midwait_next: got %0d lat %0d expected 60 lat 12", $signed(sample_out), lat); end
  endtask

  task automatic test_done_overrun();
    int lat, np;
    resp_en = 3'b111;
    resp_val[0] = 16'd1; resp_val[1] = 16'd1; resp_val[2] = 16'd1;
    frame(3'b111, 11, lat, np);
    checks++; if (np != 1) begin errors++; $display("FAIL done_overrun_pulses: got %0d expected 1", np); end
    checks++; if (gen_log.size() != 3) begin errors++; $display("FAIL done_overrun_gen: got %0d pulses expected 3", gen_log.size()); end
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL done_overrun_status: got %b expected 01", status); end
    checks++; if ($signed(sample_out) != 3) begin errors++; $display("FAIL done_overrun_sum: got %0d expected 3", $signed(sample_out)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_sparse();
    test_empty();
    test_timeout();
    test_overrun();
    test_reset_mid_wait();
    test_done_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
